// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and stall controller for the 5-stage F/D/E/M/W pipeline.
//   Handles load-use and branch hazards, and freezes the pipe while data memory
//   is not ready. Drives the stall/flush enables of every pipeline register.
//   Also provides the E-stage forwarding selects and saturating stall/flush
//   performance counters.
// Parameters
//   MEM_TIMEOUT : consecutive not-ready cycles before mem_err is raised (>= 2)
//   CNT_W       : performance counter width
// Ports
//   clk, rst_n                    : clock, async active-low reset
//   rs1_D/rs2_D, rs1_E/rs2_E      : source registers in D and E
//   rd_E/rd_M/rd_W                : destination registers in E/M/W
//   write_enable_RF_E/M/W         : register-file write enables per stage
//   write_back_E                  : E write-back select (01 = load)
//   pc_src_E                      : branch/jump taken, resolved in E
//   dmem_req_M, dmem_ready        : data memory request / completion
//   stall_F/D/E/M                 : hold PC, F->D, D->E, E->M registers
//   flush_D/E/W                   : bubble into F->D, D->E, M->W registers
//   forward_a_E/forward_b_E       : 00 RF, 01 from W, 10 from M
//   mem_err                       : sticky memory-timeout flag
//   stall_cnt/flush_cnt           : saturating counts of stall_F / flush_E cycles
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  input  logic             write_enable_RF_E,
  input  logic             write_enable_RF_M,
  input  logic             write_enable_RF_W,
  input  logic [1:0]       write_back_E,
  input  logic             pc_src_E,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       forward_a_E,
  output logic [1:0]       forward_b_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [WAIT_W-1:0]   wait_cnt_nxt_s;
  logic                mem_err_nxt_s;
  logic                load_use_s;
  logic                mem_busy_s;

  // Forward select for one E source: M result is newer, so it wins over W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       we_m,
                                         input logic [4:0] rdm,
                                         input logic       we_w,
                                         input logic [4:0] rdw);
    logic [1:0] sel;
    if (we_m && (rdm != 5'd0) && (rdm == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rdw != 5'd0) && (rdw == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Forwarding selects and hazard detection terms.
  always_comb begin
    forward_a_E = fwd_sel(rs1_E, write_enable_RF_M, rd_M, write_enable_RF_W, rd_W);
    forward_b_E = fwd_sel(rs2_E, write_enable_RF_M, rd_M, write_enable_RF_W, rd_W);
    load_use_s  = write_enable_RF_E && (write_back_E == 2'b01) && (rd_E != 5'd0) &&
                  ((rd_E == rs1_D) || (rd_E == rs2_D));
    mem_busy_s  = dmem_req_M && !dmem_ready;
  end

  // Next-state and stall/flush decode.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    mem_err_nxt_s  = mem_err;
    stall_F        = 1'b0;
    stall_D        = 1'b0;
    stall_E        = 1'b0;
    stall_M        = 1'b0;
    flush_D        = 1'b0;
    flush_E        = 1'b0;
    flush_W        = 1'b0;
    case (state_r)
      ST_RUN, ST_MEM_WAIT: begin
        // In MEM_WAIT the memory stays owed until ready, regardless of req.
        if ((state_r == ST_RUN) ? mem_busy_s : !dmem_ready) begin
          // Freeze F..M; the M->W register gets a bubble so nothing retires twice.
          stall_F = 1'b1;
          stall_D = 1'b1;
          stall_E = 1'b1;
          stall_M = 1'b1;
          flush_W = 1'b1;
          if (state_r == ST_RUN) begin
            state_nxt_s    = ST_MEM_WAIT;
            wait_cnt_nxt_s = WAIT_W'(1);
          end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_nxt_s   = ST_ERROR;
            mem_err_nxt_s = 1'b1;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
          end
        end else begin
          state_nxt_s = ST_RUN;
          if (pc_src_E) begin
            // D holds a wrong-path instruction, so a coincident load-use is moot.
            flush_D = 1'b1;
            flush_E = 1'b1;
          end else if (load_use_s) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
          end else begin
            flush_E = 1'b0;
          end
        end
      end
      ST_ERROR: begin
        stall_F       = 1'b1;
        stall_D       = 1'b1;
        stall_E       = 1'b1;
        stall_M       = 1'b1;
        flush_W       = 1'b1;
        mem_err_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s    = ST_RUN;
        wait_cnt_nxt_s = WAIT_W'(0);
      end
    endcase
  end

  // State, wait counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= WAIT_W'(0);
      mem_err    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      mem_err    <= mem_err_nxt_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (stall_F && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush_E && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=3).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       write_enable_RF_E, write_enable_RF_M, write_enable_RF_W;
  logic [1:0] write_back_E;
  logic       pc_src_E, dmem_req_M, dmem_ready;
  logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
  logic [1:0] forward_a_E, forward_b_E;
  logic       mem_err;
  logic [2:0] stall_cnt, flush_cnt;
  logic [6:0] ctrl;

  int n_checks = 0;
  int n_fails  = 0;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .write_enable_RF_E(write_enable_RF_E), .write_enable_RF_M(write_enable_RF_M),
    .write_enable_RF_W(write_enable_RF_W), .write_back_E(write_back_E),
    .pc_src_E(pc_src_E), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
    .forward_a_E(forward_a_E), .forward_b_E(forward_b_E), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}
  assign ctrl = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1_D = 5'd0; rs2_D = 5'd0; rs1_E = 5'd0; rs2_E = 5'd0;
    rd_E = 5'd0; rd_M = 5'd0; rd_W = 5'd0;
    write_enable_RF_E = 1'b0; write_enable_RF_M = 1'b0; write_enable_RF_W = 1'b0;
    write_back_E = 2'b00; pc_src_E = 1'b0; dmem_req_M = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_use(input logic [4:0] rd);
    idle();
    write_enable_RF_E = 1'b1; write_back_E = 2'b01; rd_E = rd;
    rs1_D = rd; rs2_D = 5'd1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk("reset_ctrl", int'(ctrl), 32'd0);
    chk("reset_stall_cnt", int'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", int'(flush_cnt), 32'd0);
    chk("reset_mem_err", int'(mem_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: lw x5 in E, add x6,x5,x1 in D
    load_use(5'd5);
    #1 chk("lu_ctrl", int'(ctrl), 32'b1100010);
    tick();
    idle();
    write_enable_RF_M = 1'b1; rd_M = 5'd5; rs1_E = 5'd5; rs2_E = 5'd1;
    #1 chk("lu_fwd_a", int'(forward_a_E), 32'd2);
    chk("lu_fwd_b", int'(forward_b_E), 32'd0);
    chk("lu_after_ctrl", int'(ctrl), 32'd0);
    chk("lu_stall_cnt", int'(stall_cnt), 32'd1);
    tick();

    // 2: branch taken together with load-use
    load_use(5'd3);
    pc_src_E = 1'b1;
    #1 chk("br_lu_ctrl", int'(ctrl), 32'b0000110);
    tick();
    idle();
    #1 chk("br_flush_cnt", int'(flush_cnt), 32'd2);
    chk("br_stall_cnt", int'(stall_cnt), 32'd1);

    // 3: forwarding priority
    write_enable_RF_M = 1'b1; write_enable_RF_W = 1'b1;
    rd_M = 5'd7; rd_W = 5'd7; rs1_E = 5'd7;
    #1 chk("fwd_m_wins", int'(forward_a_E), 32'd2);
    rd_M = 5'd0; rs2_E = 5'd7;
    #1 chk("fwd_rdm0_w", int'(forward_a_E), 32'd1);
    chk("fwd_b_w", int'(forward_b_E), 32'd1);
    rs1_E = 5'd0;
    #1 chk("fwd_rs0", int'(forward_a_E), 32'd0);
    tick();

    // 4: three not-ready cycles then ready (with a taken branch in E)
    idle();
    dmem_req_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("mem_wait_ctrl_%0d", i), int'(ctrl), 32'b1111001);
      tick();
    end
    dmem_ready = 1'b1;
    #1 chk("mem_ready_ctrl", int'(ctrl), 32'd0);
    pc_src_E = 1'b1;
    #1 chk("mem_ready_branch", int'(ctrl), 32'b0000110);
    tick();
    idle();
    #1 chk("mem_ok_err", int'(mem_err), 32'd0);
    chk("mem_stall_cnt", int'(stall_cnt), 32'd4);
    chk("mem_flush_cnt", int'(flush_cnt), 32'd3);

    // 5: timeout
    dmem_req_M = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #1 chk("to_err_before", int'(mem_err), 32'd0);
    tick();
    #1 chk("to_err_set", int'(mem_err), 32'd1);
    chk("to_stall_sat", int'(stall_cnt), 32'd7);
    idle();
    dmem_ready = 1'b1;
    #1 chk("err_hold_ctrl", int'(ctrl), 32'b1111001);
    tick();
    #1 chk("err_sticky", int'(mem_err), 32'd1);
    chk("err_hold_ctrl2", int'(ctrl), 32'b1111001);
    rst_n = 1'b0;
    #1 chk("rst_ctrl", int'(ctrl), 32'd0);
    chk("rst_err", int'(mem_err), 32'd0);
    chk("rst_stall_cnt", int'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", int'(flush_cnt), 32'd0);
    #1 rst_n = 1'b1;
    tick();

    // 6: rd_E == 0 never stalls; counter saturation
    load_use(5'd0);
    #1 chk("rd0_no_stall", int'(ctrl), 32'd0);
    tick();
    for (int i = 0; i < 9; i++) begin
      load_use(5'd9);
      #1;
      tick();
      idle();
      #1;
      if (i == 5) chk("sat_stall_6", int'(stall_cnt), 32'd6);
      tick();
    end
    chk("sat_stall_cnt", int'(stall_cnt), 32'd7);
    chk("sat_flush_cnt", int'(flush_cnt), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
